// File: rtl/router_vc_fifo_if.sv
// router_vc_fifo_if
//   Bundles the shared write port, per-VC read requests and per-VC status/data
//   of the multi-VC router input buffer.
//   master : producer/VC-allocator side (drives wrreq, wr_vc, data_in, rdreq)
//   slave  : the buffer itself
//   Signals:
//     wrreq        push data_in into VC wr_vc
//     wr_vc        target VC of the write
//     data_in      flit to push
//     rdreq        per-VC pop request
//     empty/full/almost_full/has_tail   per-VC status
//     data_out     head flit per VC
//     credit_out   per-VC credit pulse (only with ROUTER_VC_FIFO_CREDIT_EN)
interface router_vc_fifo_if #(
    parameter int NumVc = 2,
    parameter int Width = 66
);
    localparam int VcW = (NumVc > 1) ? $clog2(NumVc) : 1;

    logic                          wrreq;
    logic [VcW-1:0]                wr_vc;
    logic [Width-1:0]              data_in;
    logic [NumVc-1:0]              rdreq;
    logic [NumVc-1:0]              empty;
    logic [NumVc-1:0]              full;
    logic [NumVc-1:0]              almost_full;
    logic [NumVc-1:0]              has_tail;
    logic [NumVc-1:0][Width-1:0]   data_out;
`ifdef ROUTER_VC_FIFO_CREDIT_EN
    logic [NumVc-1:0]              credit_out;

    modport master (
        output wrreq, wr_vc, data_in, rdreq,
        input  empty, full, almost_full, has_tail, data_out, credit_out
    );
    modport slave (
        input  wrreq, wr_vc, data_in, rdreq,
        output empty, full, almost_full, has_tail, data_out, credit_out
    );
`else
    modport master (
        output wrreq, wr_vc, data_in, rdreq,
        input  empty, full, almost_full, has_tail, data_out
    );
    modport slave (
        input  wrreq, wr_vc, data_in, rdreq,
        output empty, full, almost_full, has_tail, data_out
    );
`endif
endinterface

// File: rtl/router_vc_fifo.sv
// router_vc_fifo
//   Multi-virtual-channel input buffer: NumVc independent circular FIFOs that
//   share one write port, each with its own read port, occupancy flags and a
//   count of stored tail/single flits so the allocator only schedules complete
//   packets.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset (clears contents, pointers, flags)
//     bus   router_vc_fifo_if.slave (write port, per-VC read/status/data)
//   Optional feature macro: ROUTER_VC_FIFO_CREDIT_EN adds bus.credit_out, a
//   one-cycle per-VC pulse after every valid read or bypass.
module router_vc_fifo #(
    parameter bit BypassEnable  = 1'b1,
    parameter int NumVc         = 2,
    parameter int Depth         = 4,
    parameter int Width         = 66,
    parameter int AlmostFullThr = 1
) (
    input  logic              clk,
    input  logic              rst,
    router_vc_fifo_if.slave   bus
);
    localparam int VcW  = (NumVc > 1) ? $clog2(NumVc) : 1;
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth + 1);

    logic [NumVc-1:0] w_hit;
    logic [NumVc-1:0] w_empty;
    logic [NumVc-1:0] w_full;
    logic [NumVc-1:0] w_bypass;
    logic [NumVc-1:0] w_push;
    logic [NumVc-1:0] w_pop;

    for (genvar v = 0; v < NumVc; v++) begin : g_vc
        logic [Width-1:0] r_mem [Depth];
        logic [PtrW-1:0]  r_head;
        logic [PtrW-1:0]  r_tail;
        logic [CntW-1:0]  r_used;
        logic [CntW-1:0]  r_tailcnt;
        logic [Width-1:0] w_head_flit;
        logic             w_in_tail;
        logic             w_head_tail;
        logic             w_tc_inc;
        logic             w_tc_dec;

        assign w_hit[v]   = bus.wrreq && (bus.wr_vc == VcW'(v));
        assign w_empty[v] = (r_used == '0);
        assign w_full[v]  = (r_used == CntW'(Depth));

        // A flit that is read in the same cycle it arrives at an empty VC is
        // forwarded straight through and never stored.
        assign w_bypass[v] = BypassEnable && w_empty[v] && w_hit[v] && bus.rdreq[v];
        assign w_push[v]   = w_hit[v] && !w_full[v] && !w_bypass[v];
        assign w_pop[v]    = bus.rdreq[v] && !w_empty[v];

        assign w_head_flit = r_mem[r_head];
        // Types 01 (tail) and 11 (single) both end a packet: low type bit set.
        assign w_in_tail   = bus.data_in[Width-2];
        assign w_head_tail = w_head_flit[Width-2];
        assign w_tc_inc    = w_push[v] && w_in_tail;
        assign w_tc_dec    = w_pop[v] && w_head_tail;

        assign bus.empty[v]       = w_empty[v];
        assign bus.full[v]        = w_full[v];
        assign bus.almost_full[v] = (CntW'(Depth) - r_used) <= CntW'(AlmostFullThr);
        assign bus.has_tail[v]    = (r_tailcnt != '0);
        assign bus.data_out[v]    = (BypassEnable && w_empty[v]) ? bus.data_in : w_head_flit;

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int d = 0; d < Depth; d++) begin
                    r_mem[d] <= '0;
                end
                r_head    <= '0;
                r_tail    <= '0;
                r_used    <= '0;
                r_tailcnt <= '0;
            end else begin
                if (w_push[v]) begin
                    r_mem[r_tail] <= bus.data_in;
                    r_tail        <= (r_tail == PtrW'(Depth - 1)) ? '0 : r_tail + PtrW'(1);
                end
                if (w_pop[v]) begin
                    r_head <= (r_head == PtrW'(Depth - 1)) ? '0 : r_head + PtrW'(1);
                end
                case ({w_push[v], w_pop[v]})
                    2'b10:   r_used <= r_used + CntW'(1);
                    2'b01:   r_used <= r_used - CntW'(1);
                    default: r_used <= r_used;
                endcase
                case ({w_tc_inc, w_tc_dec})
                    2'b10:   r_tailcnt <= r_tailcnt + CntW'(1);
                    2'b01:   r_tailcnt <= r_tailcnt - CntW'(1);
                    default: r_tailcnt <= r_tailcnt;
                endcase
            end
        end

        a_ptr_range : assert property (@(posedge clk) disable iff (rst)
            (32'(r_head) < Depth) && (32'(r_tail) < Depth));
        a_used_range : assert property (@(posedge clk) disable iff (rst)
            32'(r_used) <= Depth);
        a_full_empty : assert property (@(posedge clk) disable iff (rst)
            !(w_full[v] && w_empty[v]));
        a_tailcnt : assert property (@(posedge clk) disable iff (rst)
            r_tailcnt <= r_used);
    end

`ifdef ROUTER_VC_FIFO_CREDIT_EN
    logic [NumVc-1:0] r_credit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit <= '0;
        end else begin
            r_credit <= w_pop | w_bypass;
        end
    end

    assign bus.credit_out = r_credit;
`endif

endmodule

// File: tb/tb_router_vc_fifo.sv
// tb_router_vc_fifo
//   Directed bench for router_vc_fifo with default parameters
//   (NumVc=2, Depth=4, Width=66, AlmostFullThr=1, BypassEnable=1).
module tb_router_vc_fifo;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    router_vc_fifo_if #(.NumVc(2), .Width(66)) bus ();

    router_vc_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [65:0] flit(input logic [1:0] t, input logic [63:0] p);
        return {t, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wrreq   = 1'b0;
        bus.wr_vc   = 1'b0;
        bus.data_in = '0;
        bus.rdreq   = 2'b00;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.data_in = flit(2'b10, 64'hDEAD_BEEF);
        #1;
        n_checks++;
        if (bus.empty !== 2'b11) begin
            n_fail++; $display("FAIL reset_empty got=%b exp=11", bus.empty);
        end
        n_checks++;
        if (bus.full !== 2'b00) begin
            n_fail++; $display("FAIL reset_full got=%b exp=00", bus.full);
        end
        n_checks++;
        if (bus.almost_full !== 2'b00) begin
            n_fail++; $display("FAIL reset_afull got=%b exp=00", bus.almost_full);
        end
        n_checks++;
        if (bus.has_tail !== 2'b00) begin
            n_fail++; $display("FAIL reset_has_tail got=%b exp=00", bus.has_tail);
        end
        n_checks++;
        if (bus.data_out[0] !== flit(2'b10, 64'hDEAD_BEEF) || bus.data_out[1] !== flit(2'b10, 64'hDEAD_BEEF)) begin
            n_fail++; $display("FAIL reset_data_out got0=%h got1=%h exp=%h", bus.data_out[0], bus.data_out[1], flit(2'b10, 64'hDEAD_BEEF));
        end
`ifdef ROUTER_VC_FIFO_CREDIT_EN
        n_checks++;
        if (bus.credit_out !== 2'b00) begin
            n_fail++; $display("FAIL reset_credit got=%b exp=00", bus.credit_out);
        end
`endif
        idle_inputs();
    endtask

    task automatic test_fill_drop();
        logic [65:0] f [5];
        logic        exp_af;
        logic        exp_full;
        for (int i = 0; i < 5; i++) f[i] = flit(2'b00, 64'hA0 + 64'(i));
        for (int i = 0; i < 5; i++) begin
            bus.wrreq = 1'b1; bus.wr_vc = 1'b0; bus.data_in = f[i];
            tick();
            // free entries after i+1 accepted writes: 3,2,1,0,0
            exp_af   = (i >= 2);
            exp_full = (i >= 3);
            n_checks++;
            if (bus.almost_full[0] !== exp_af) begin
                n_fail++; $display("FAIL fill_afull write=%0d got=%b exp=%b", i, bus.almost_full[0], exp_af);
            end
            n_checks++;
            if (bus.full[0] !== exp_full) begin
                n_fail++; $display("FAIL fill_full write=%0d got=%b exp=%b", i, bus.full[0], exp_full);
            end
        end
        idle_inputs();
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.data_out[0] !== f[i]) begin
                n_fail++; $display("FAIL fill_read idx=%0d got=%h exp=%h", i, bus.data_out[0], f[i]);
            end
            bus.rdreq = 2'b01;
            tick();
            bus.rdreq = 2'b00;
        end
        n_checks++;
        if (bus.empty !== 2'b11) begin
            n_fail++; $display("FAIL fill_drained_empty got=%b exp=11", bus.empty);
        end
    endtask

    task automatic test_packets();
        logic [65:0] wr_flit [6];
        logic        wr_vcs  [6];
        logic [1:0]  exp_tail_wr [6];
        logic [65:0] rd_flit [6];
        logic [1:0]  rd_req  [6];
        logic [1:0]  exp_tail_rd [6];
        wr_flit = '{flit(2'b10, 64'h200), flit(2'b10, 64'h210), flit(2'b00, 64'h001),
                    flit(2'b00, 64'h011), flit(2'b01, 64'h100), flit(2'b01, 64'h110)};
        wr_vcs      = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_tail_wr = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11};
        rd_flit = '{flit(2'b10, 64'h200), flit(2'b00, 64'h001), flit(2'b01, 64'h100),
                    flit(2'b10, 64'h210), flit(2'b00, 64'h011), flit(2'b01, 64'h110)};
        rd_req      = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
        exp_tail_rd = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b00};
        for (int i = 0; i < 6; i++) begin
            bus.wrreq = 1'b1; bus.wr_vc = wr_vcs[i]; bus.data_in = wr_flit[i];
            tick();
            n_checks++;
            if (bus.has_tail !== exp_tail_wr[i]) begin
                n_fail++; $display("FAIL pkt_has_tail_wr step=%0d got=%b exp=%b", i, bus.has_tail, exp_tail_wr[i]);
            end
        end
        idle_inputs();
        #1;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (bus.data_out[(rd_req[i] == 2'b01) ? 0 : 1] !== rd_flit[i]) begin
                n_fail++; $display("FAIL pkt_read step=%0d got=%h exp=%h", i, bus.data_out[(rd_req[i] == 2'b01) ? 0 : 1], rd_flit[i]);
            end
            bus.rdreq = rd_req[i];
            tick();
            bus.rdreq = 2'b00;
            n_checks++;
            if (bus.has_tail !== exp_tail_rd[i]) begin
                n_fail++; $display("FAIL pkt_has_tail_rd step=%0d got=%b exp=%b", i, bus.has_tail, exp_tail_rd[i]);
            end
        end
        n_checks++;
        if (bus.empty !== 2'b11) begin
            n_fail++; $display("FAIL pkt_empty got=%b exp=11", bus.empty);
        end
    endtask

    task automatic test_bypass();
        bus.wrreq = 1'b1; bus.wr_vc = 1'b1; bus.data_in = flit(2'b01, 64'hB1); bus.rdreq = 2'b10;
        #1;
        n_checks++;
        if (bus.data_out[1] !== flit(2'b01, 64'hB1)) begin
            n_fail++; $display("FAIL bypass_data got=%h exp=%h", bus.data_out[1], flit(2'b01, 64'hB1));
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (bus.empty[1] !== 1'b1 || bus.has_tail[1] !== 1'b0) begin
            n_fail++; $display("FAIL bypass_not_stored empty=%b has_tail=%b exp=1/0", bus.empty[1], bus.has_tail[1]);
        end
`ifdef ROUTER_VC_FIFO_CREDIT_EN
        n_checks++;
        if (bus.credit_out !== 2'b10) begin
            n_fail++; $display("FAIL bypass_credit got=%b exp=10", bus.credit_out);
        end
`endif
        // Plain write without read: stored, visible one cycle later.
        bus.wrreq = 1'b1; bus.wr_vc = 1'b1; bus.data_in = flit(2'b01, 64'hB2);
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (bus.data_out[1] !== flit(2'b01, 64'hB2) || bus.empty[1] !== 1'b0 || bus.has_tail[1] !== 1'b1) begin
            n_fail++; $display("FAIL stored_single data=%h empty=%b has_tail=%b exp=%h/0/1", bus.data_out[1], bus.empty[1], bus.has_tail[1], flit(2'b01, 64'hB2));
        end
`ifdef ROUTER_VC_FIFO_CREDIT_EN
        n_checks++;
        if (bus.credit_out !== 2'b00) begin
            n_fail++; $display("FAIL credit_idle got=%b exp=00", bus.credit_out);
        end
`endif
        bus.rdreq = 2'b10;
        tick();
        bus.rdreq = 2'b00;
        n_checks++;
        if (bus.empty !== 2'b11 || bus.has_tail !== 2'b00) begin
            n_fail++; $display("FAIL stored_single_drain empty=%b has_tail=%b exp=11/00", bus.empty, bus.has_tail);
        end
    endtask

    task automatic test_wrap();
        logic [65:0] a [4];
        logic [65:0] b [10];
        logic [65:0] exp_out [13];
        for (int i = 0; i < 4; i++)  a[i] = flit(2'b00, 64'hC0 + 64'(i));
        for (int i = 0; i < 10; i++) b[i] = flit(2'b00, 64'hD0 + 64'(i));
        // First combined cycle hits a full VC: its write (b[0]) is dropped
        // while the read proceeds, so output is a0..a3 then b1..b9.
        for (int k = 0; k < 13; k++) exp_out[k] = (k < 4) ? a[k] : b[k - 3];
        for (int i = 0; i < 4; i++) begin
            bus.wrreq = 1'b1; bus.wr_vc = 1'b0; bus.data_in = a[i];
            tick();
        end
        n_checks++;
        if (bus.full[0] !== 1'b1) begin
            n_fail++; $display("FAIL wrap_prefill_full got=%b exp=1", bus.full[0]);
        end
        for (int i = 0; i < 10; i++) begin
            bus.wrreq = 1'b1; bus.wr_vc = 1'b0; bus.data_in = b[i]; bus.rdreq = 2'b01;
            #1;
            n_checks++;
            if (bus.data_out[0] !== exp_out[i]) begin
                n_fail++; $display("FAIL wrap_out cycle=%0d got=%h exp=%h", i, bus.data_out[0], exp_out[i]);
            end
            tick();
`ifdef ROUTER_VC_FIFO_CREDIT_EN
            n_checks++;
            if (bus.credit_out !== 2'b01) begin
                n_fail++; $display("FAIL wrap_credit cycle=%0d got=%b exp=01", i, bus.credit_out);
            end
`endif
        end
        idle_inputs();
        n_checks++;
        if (bus.full[0] !== 1'b0 || bus.almost_full[0] !== 1'b1) begin
            n_fail++; $display("FAIL wrap_steady_flags full=%b afull=%b exp=0/1", bus.full[0], bus.almost_full[0]);
        end
        for (int k = 10; k < 13; k++) begin
            #1;
            n_checks++;
            if (bus.data_out[0] !== exp_out[k]) begin
                n_fail++; $display("FAIL wrap_drain idx=%0d got=%h exp=%h", k, bus.data_out[0], exp_out[k]);
            end
            bus.rdreq = 2'b01;
            tick();
            bus.rdreq = 2'b00;
        end
        n_checks++;
        if (bus.empty !== 2'b11) begin
            n_fail++; $display("FAIL wrap_empty got=%b exp=11", bus.empty);
        end
    endtask

    task automatic test_reset_mid();
        logic [65:0] w [4];
        logic        vcs [4];
        w   = '{flit(2'b10, 64'hE0), flit(2'b01, 64'hE1), flit(2'b10, 64'hE2), flit(2'b01, 64'hE3)};
        vcs = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            bus.wrreq = 1'b1; bus.wr_vc = vcs[i]; bus.data_in = w[i];
            tick();
        end
        idle_inputs();
        n_checks++;
        if (bus.has_tail !== 2'b11 || bus.empty !== 2'b00) begin
            n_fail++; $display("FAIL mid_prefill has_tail=%b empty=%b exp=11/00", bus.has_tail, bus.empty);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.data_in = flit(2'b00, 64'h5555);
        #1;
        n_checks++;
        if (bus.empty !== 2'b11 || bus.full !== 2'b00 || bus.almost_full !== 2'b00 || bus.has_tail !== 2'b00) begin
            n_fail++; $display("FAIL mid_reset_flags empty=%b full=%b afull=%b has_tail=%b exp=11/00/00/00", bus.empty, bus.full, bus.almost_full, bus.has_tail);
        end
        n_checks++;
        if (bus.data_out[0] !== flit(2'b00, 64'h5555) || bus.data_out[1] !== flit(2'b00, 64'h5555)) begin
            n_fail++; $display("FAIL mid_reset_data got0=%h got1=%h exp=%h", bus.data_out[0], bus.data_out[1], flit(2'b00, 64'h5555));
        end
        bus.wrreq = 1'b1; bus.wr_vc = 1'b0; bus.data_in = flit(2'b11, 64'hF0);
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (bus.data_out[0] !== flit(2'b11, 64'hF0) || bus.empty !== 2'b10 || bus.has_tail !== 2'b01) begin
            n_fail++; $display("FAIL mid_reset_newflit data=%h empty=%b has_tail=%b exp=%h/10/01", bus.data_out[0], bus.empty, bus.has_tail, flit(2'b11, 64'hF0));
        end
        bus.rdreq = 2'b01;
        tick();
        bus.rdreq = 2'b00;
        n_checks++;
        if (bus.empty !== 2'b11 || bus.has_tail !== 2'b00) begin
            n_fail++; $display("FAIL mid_reset_drain empty=%b has_tail=%b exp=11/00", bus.empty, bus.has_tail);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_fill_drop();
        test_packets();
        test_bypass();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/router_vc_fifo.md
# router_vc_fifo

Multi-virtual-channel input buffer for the packet-switched router. It replaces the single-queue router FIFO on each input port with NumVc independent FIFOs that share one write port. Each VC has its own read port, occupancy flags and tail-flit tracking. The VC allocator reads these flags to schedule only complete packets and to apply back-pressure before a VC fills.

## Interface
Parameters:
- BypassEnable, 1'b1: zero-cycle forwarding from data_in to a VC's data_out while that VC is empty.
- NumVc, 2: number of virtual channels; must be at least 1.
- Depth, 4: entries per VC; must be at least 2; need not be a power of two.
- Width, 66: flit width; must be at least 3; flit type is data_in[Width-1:Width-2].
- AlmostFullThr, 1: almost_full asserts when free entries ≤ AlmostFullThr; valid range is 0..Depth-1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wrreq  in  1  push data_in into VC wr_vc.
- wr_vc  in  max(1,$clog2(NumVc))  target VC of the write; values ≥ NumVc are ignored.
- data_in  in  Width  flit to push.
- rdreq  in  NumVc  per-VC pop request.
- empty  out  NumVc  VC holds no flits.
- full  out  NumVc  VC holds Depth flits.
- almost_full  out  NumVc  free entries ≤ AlmostFullThr.
- has_tail  out  NumVc  VC holds at least one tail (2'b01) or single-flit (2'b11) flit.
- data_out  out  NumVc×Width  head flit per VC.

## Operation
- Each VC is a circular buffer with binary head and tail pointers. Both pointers wrap from Depth-1 to 0.
- Each VC has a used counter of width $clog2(Depth+1).
- A write is accepted for VC v when wrreq=1, wr_vc=v and full[v]=0.
  - A write to a full VC is dropped and state is unchanged, even if rdreq[v]=1 in the same cycle.
- A read is valid for VC v when rdreq[v]=1 and empty[v]=0.
  - rdreq on an empty VC has no effect unless bypass applies (below).
- Bypass applies when BypassEnable=1, empty[v]=1, and a write to v coincides with rdreq[v]=1.
  - data_out[v]=data_in combinationally.
  - Nothing is stored; used, pointers and has_tail are unchanged.
- When BypassEnable=1 and empty[v]=1, data_out[v]=data_in regardless of wr_vc.
- Otherwise data_out[v] is the entry at head[v].
- Simultaneous valid read and accepted write on the same non-empty VC: both occur and used is unchanged.
- Writes and reads on different VCs are fully independent.
- tailcnt[v] counts stored flits of type 01 or 11.
  - Increments on an accepted stored write of such a flit.
  - Decrements on a valid read whose head flit is such a type.
  - Increment and decrement in the same cycle cancel.
  - has_tail[v] = (tailcnt[v]≠0).
- Derived flags: empty = (used==0); full = (used==Depth); almost_full = (Depth-used ≤ AlmostFullThr).
- Storage is reset to 0.
- A reset asserted mid-operation discards all contents on that edge.

## Timing
- Write-to-visible latency is 1 cycle: a flit written at edge N is at data_out from N+1 if the VC was empty.
- Bypass latency is 0 cycles.
- Flags update on the edge after the causing request. has_tail follows the same 1-cycle rule.
- Reset values, sampled in the cycle after rst:
  - empty all 1; full, almost_full and has_tail all 0.
  - data_out[v] = data_in if BypassEnable, else 0.
- Assertions, under disable iff(rst):
  - head and tail are always < Depth.
  - used ≤ Depth.
  - full and empty are never both 1 for the same VC.
  - tailcnt ≤ used.

## Configuration
- ROUTER_VC_FIFO_CREDIT_EN defined: adds output credit_out (NumVc bits).
  - credit_out[v] pulses high for exactly one cycle, on the cycle after each valid read or bypass of VC v.
  - credit_out resets to 0.
- ROUTER_VC_FIFO_CREDIT_EN undefined: the credit_out port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset, then idle: empty=2'b11, full=0, almost_full=0, has_tail=0 for NumVc=2, Depth=4, AlmostFullThr=1.
- Write 3 flits to VC0: almost_full[0]=1 after the third edge. A fourth write sets full[0]=1. A fifth write is dropped, and the next 4 reads return the first 4 flits in order.
- Interleave writes to VC0 and VC1, with header 0x2…, body 0x0…, tail 0x1… on each. has_tail[v] rises only after v's tail is written and falls after it is read. VC contents never mix.
- Bypass: with VC1 empty, wrreq=1, wr_vc=1 and rdreq=2'b10 in the same cycle. data_out[1]=data_in in that cycle; empty[1] stays 1 on the next cycle.
- Fill VC0 to 4 entries and run 10 cycles of simultaneous read+write. Head and tail pointers wrap and the output order is preserved. With credit enabled, credit_out[0] is high on each of the 10 following cycles.
- Assert rst with both VCs half full: on the next cycle all flags return to reset values and stored flits are unreadable.
